// File: rtl/fsm_pkg.sv
// Shared definitions for the serial odd-detector scheduler: frame kinds,
// slice geometry and the slot counter step.
package fsm_pkg;

    localparam int SLICE_W   = 3;
    localparam int DET_PULSE = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } frame_state_t;

    function automatic logic [1:0] slot_step(input logic [1:0] slot);
        return (slot == 2'(SLICE_W - 1)) ? 2'd0 : slot + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the
// pointer, searching upward and wrapping at N.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] winner,
    output logic           any
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            // ptr is always below N, so one subtraction is enough to wrap
            if (int'(ptr) + i >= N) begin
                idx = IW'(int'(ptr) + i - N);
            end else begin
                idx = IW'(int'(ptr) + i);
            end
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                winner     = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/fsm_serial_sched.sv
// Shares one serial 3-bit odd detector between N requesters: DATA frame
// shifts the granted value out MSB first, CHECK frame collects the verdict.
module fsm_serial_sched
    import fsm_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [SLICE_W*N-1:0] data,
    output logic [N-1:0]         grant,
    output logic                 ser_out,
    input  logic                 det_in,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic                 res_odd,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    // Handshake: req is a level; grant pulses for the one slot-2 cycle in
    // which data[k] is captured. res_valid is a one-cycle strobe, res_id and
    // res_odd hold until the next strobe.

    frame_state_t state, state_d;
    logic [1:0]           slot;
    logic                 slot_last;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       cur_id;
    logic [N-1:0]         arb_grant;
    logic [IDW-1:0]       arb_winner;
    logic                 arb_any;
    logic                 take;
    logic [SLICE_W-1:0]   win_data;
    logic [SLICE_W-2:0]   shreg;
    logic                 seen;
    logic                 check_end;

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req    (req),
        .ptr    (rr_ptr),
        .grant  (arb_grant),
        .winner (arb_winner),
        .any    (arb_any)
    );

    assign slot_last = (slot == 2'(SLICE_W - 1));
    assign check_end = (state == CHECK) && slot_last;
    assign win_data  = SLICE_W'(data >> (SLICE_W * int'(arb_winner)));

    always_comb begin
        state_d = state;
        take    = 1'b0;
        if (slot_last) begin
            if (state == DATA) begin
                state_d = CHECK;
            end else if (arb_any) begin
                state_d = DATA;
                take    = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign grant     = take ? arb_grant : '0;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            slot  <= 2'd0;
        end else begin
            state <= state_d;
            slot  <= slot_step(slot);
        end
    end

    // ser_out leads the frame by one edge: bit[2] is loaded on the grant edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            cur_id  <= '0;
            shreg   <= '0;
            ser_out <= 1'b0;
        end else if (take) begin
            cur_id  <= arb_winner;
            rr_ptr  <= (arb_winner == IDW'(N - 1)) ? '0 : arb_winner + IDW'(1);
            ser_out <= win_data[SLICE_W-1];
            shreg   <= win_data[SLICE_W-2:0];
        end else if ((state == DATA) && !slot_last) begin
            ser_out <= shreg[SLICE_W-2];
            shreg   <= shreg << 1;
        end else begin
            ser_out <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen      <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_odd   <= 1'b0;
        end else begin
            if ((state == DATA) && slot_last) begin
                seen <= 1'b0;
            end else if (state == CHECK) begin
                seen <= seen | det_in;
            end
            res_valid <= check_end;
            if (check_end) begin
                res_id  <= cur_id;
                res_odd <= seen | det_in;
            end
        end
    end

endmodule

// File: tb/tb_fsm_serial_sched.sv
// Bench for fsm_serial_sched: a frame-level reference model plus a behavioural
// odd detector fed from ser_out, with directed and randomized scenarios.
module tb_fsm_serial_sched;
  import fsm_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int KW  = $clog2(N);
  localparam int QW  = 16 + IDW + 1;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [3*N-1:0] data = '0;
  logic [N-1:0]   grant;
  logic           ser_out;
  logic           det_in = 1'b0;
  logic           res_valid;
  logic [IDW-1:0] res_id;
  logic           res_odd;
  logic           busy;
  logic [1:0]     dbg_state;

  fsm_serial_sched #(.N(N), .IDW(IDW)) dut (
    .clock(clock), .reset(reset), .req(req), .data(data), .grant(grant),
    .ser_out(ser_out), .det_in(det_in), .res_valid(res_valid), .res_id(res_id),
    .res_odd(res_odd), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  // Reference model state: cycle index from reset release, last grant cycle
  int             cyc, now_c, last_g, ptr_m, det_cnt;
  logic [2:0]     last_val;
  logic [N-1:0]   exp_grant;
  logic           exp_ser, exp_busy, exp_valid, exp_odd;
  logic [IDW-1:0] exp_id;
  logic [QW-1:0]  exp_q[$];
  logic [N-1:0]   req_nx = '0;
  logic [3*N-1:0] data_nx = '0;
  logic           force_det = 1'b0;
  int             n_cmp = 0;
  int             n_bad = 0;

  function automatic void model_cycle();
    int slot, d, k;
    logic found;
    logic [KW-1:0] kb;
    logic [2:0] sh;
    logic [QW-1:0] head;
    slot = cyc % 3;
    d = cyc - last_g;
    now_c = cyc;
    exp_busy = (d >= 1 && d <= 6);
    sh = last_val << (d - 1);
    exp_ser = (d >= 1 && d <= 3) ? sh[2] : 1'b0;
    exp_grant = '0;
    found = 1'b0;
    if (slot == 2 && !(d >= 1 && d <= 3)) begin
      for (int i = 0; i < N; i++) begin
        k = (ptr_m + i) % N;
        kb = KW'(k);
        if (!found && req[kb]) begin
          found = 1'b1;
          exp_grant[kb] = 1'b1;
          last_g = cyc;
          last_val = data[3*k +: 3];
          exp_q.push_back({16'(cyc + 7), IDW'(k), last_val[0]});
          ptr_m = (k + 1) % N;
        end
      end
    end
    exp_valid = 1'b0;
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      if (head[QW-1 -: 16] == 16'(cyc)) begin
        exp_valid = 1'b1;
        exp_id = head[IDW:1];
        exp_odd = head[0];
        void'(exp_q.pop_front());
      end
    end
    // detector: a slice whose last (LSB) bit is 1 is odd; pulse over next frame
    if (slot == 2) det_cnt = ser_out ? DET_PULSE : 0;
    else if (det_cnt > 0) det_cnt--;
    cyc++;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    req = req_nx;
    data = data_nx;
    det_in = (det_cnt > 0) | force_det;
    @(negedge clock);
    model_cycle();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    cyc = 0; last_g = -100; ptr_m = 0; det_cnt = 0; last_val = '0;
    exp_q.delete();
    exp_grant = '0; exp_ser = 0; exp_busy = 0; exp_valid = 0; exp_odd = 0; exp_id = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    req = req_nx;
    data = data_nx;
    det_in = force_det;
    @(negedge clock);
    model_cycle();
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_cmp++; if ({grant, ser_out, res_valid, res_id, res_odd, busy, dbg_state} !== '0) begin
      n_bad++; $display("FAIL reset_outs got=%b exp=0", {grant, ser_out, res_valid, res_id, res_odd, busy, dbg_state}); end
    req_nx = '0;
    reset_dut();
    for (int t = 0; t < 30; t++) begin
      tick();
      n_cmp++; if (ser_out !== exp_ser) begin n_bad++; $display("FAIL idle_ser c=%0d got=%b exp=%b", now_c, ser_out, exp_ser); end
      n_cmp++; if (grant !== exp_grant) begin n_bad++; $display("FAIL idle_grant c=%0d got=%b exp=%b", now_c, grant, exp_grant); end
      n_cmp++; if (res_valid !== exp_valid) begin n_bad++; $display("FAIL idle_valid c=%0d got=%b exp=%b", now_c, res_valid, exp_valid); end
      n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL idle_busy c=%0d got=%b exp=%b", now_c, busy, exp_busy); end
    end
  endtask

  task automatic test_single(input int k, input logic [2:0] v);
    logic [KW-1:0] kb;
    int g_c, v_c, nvalid;
    kb = KW'(k); g_c = -100; v_c = -1; nvalid = 0;
    req_nx[kb] = 1'b1;
    data_nx[3*k +: 3] = v;
    for (int t = 0; t < 16; t++) begin
      tick();
      n_cmp++; if (grant !== exp_grant) begin n_bad++; $display("FAIL single_grant c=%0d got=%b exp=%b", now_c, grant, exp_grant); end
      n_cmp++; if (ser_out !== exp_ser) begin n_bad++; $display("FAIL single_ser c=%0d got=%b exp=%b", now_c, ser_out, exp_ser); end
      n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL single_busy c=%0d got=%b exp=%b", now_c, busy, exp_busy); end
      n_cmp++; if (res_valid !== exp_valid) begin n_bad++; $display("FAIL single_valid c=%0d got=%b exp=%b", now_c, res_valid, exp_valid); end
      n_cmp++; if ({res_id, res_odd} !== {exp_id, exp_odd}) begin n_bad++;
        $display("FAIL single_result c=%0d got=%0d/%b exp=%0d/%b", now_c, res_id, res_odd, exp_id, exp_odd); end
      if (grant[kb]) g_c = now_c;
      if (res_valid) begin v_c = now_c; nvalid++; end
      if (exp_grant[kb]) req_nx[kb] = 1'b0;
    end
    n_cmp++; if (nvalid != 1 || v_c - g_c != 7) begin n_bad++;
      $display("FAIL single_latency got=%0d strobes=%0d exp=7 strobes=1", v_c - g_c, nvalid); end
    n_cmp++; if ({res_id, res_odd} !== {IDW'(k), v[0]}) begin n_bad++;
      $display("FAIL single_verdict got=%0d/%b exp=%0d/%b", res_id, res_odd, k, v[0]); end
  endtask

  task automatic test_back_to_back();
    int order[$];
    int gcyc[$];
    logic odds[$];
    req_nx = '1;
    data_nx = {3'b100, 3'b011, 3'b010, 3'b001};
    reset_dut();
    for (int t = 0; t < 46; t++) begin
      if (t == 34) req_nx = '0;
      tick();
      n_cmp++; if (grant !== exp_grant) begin n_bad++; $display("FAIL b2b_grant c=%0d got=%b exp=%b", now_c, grant, exp_grant); end
      n_cmp++; if (ser_out !== exp_ser) begin n_bad++; $display("FAIL b2b_ser c=%0d got=%b exp=%b", now_c, ser_out, exp_ser); end
      n_cmp++; if (res_valid !== exp_valid) begin n_bad++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", now_c, res_valid, exp_valid); end
      n_cmp++; if ({res_id, res_odd} !== {exp_id, exp_odd}) begin n_bad++;
        $display("FAIL b2b_result c=%0d got=%0d/%b exp=%0d/%b", now_c, res_id, res_odd, exp_id, exp_odd); end
      for (int i = 0; i < N; i++) if (grant[i[KW-1:0]]) begin order.push_back(i); gcyc.push_back(now_c); end
      if (res_valid) odds.push_back(res_odd);
    end
    n_cmp++; if (order.size() < 5 || odds.size() < 5) begin n_bad++;
      $display("FAIL b2b_count got=%0d/%0d exp>=5", order.size(), odds.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++; if (order[i] != i % N || gcyc[i] != 2 + 6 * i) begin n_bad++;
          $display("FAIL b2b_order i=%0d got=%0d@%0d exp=%0d@%0d", i, order[i], gcyc[i], i % N, 2 + 6 * i); end
        n_cmp++; if (odds[i] !== 1'((i % N + 1) & 1)) begin n_bad++;
          $display("FAIL b2b_odd i=%0d got=%b exp=%b", i, odds[i], 1'((i % N + 1) & 1)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    logic seen_g;
    req_nx = '0; req_nx[3] = 1'b1; data_nx[11:9] = 3'b111;
    t = 0; seen_g = 1'b0;
    while (!seen_g && t < 10) begin
      tick(); t++;
      n_cmp++; if (grant !== exp_grant) begin n_bad++; $display("FAIL mid_grant c=%0d got=%b exp=%b", now_c, grant, exp_grant); end
      seen_g = exp_grant[3];
    end
    n_cmp++; if (!seen_g) begin n_bad++; $display("FAIL mid_timeout got=no_grant exp=grant"); end
    tick();
    n_cmp++; if (ser_out !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_data got=%b%b exp=11", ser_out, busy); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({grant, ser_out, res_valid, res_id, res_odd, busy, dbg_state} !== '0) begin
      n_bad++; $display("FAIL mid_reset_outs got=%b exp=0", {grant, ser_out, res_valid, res_id, res_odd, busy, dbg_state}); end
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_abandon got=%b%b exp=00", res_valid, busy); end
    end
    reset_dut();
    for (int i = 0; i < 14; i++) begin
      tick();
      n_cmp++; if (grant !== exp_grant) begin n_bad++; $display("FAIL mid_re_grant c=%0d got=%b exp=%b", now_c, grant, exp_grant); end
      if (now_c == 2) begin
        n_cmp++; if (grant !== 4'b1000) begin n_bad++; $display("FAIL mid_first c=2 got=%b exp=1000", grant); end
      end
      n_cmp++; if (ser_out !== exp_ser) begin n_bad++; $display("FAIL mid_ser c=%0d got=%b exp=%b", now_c, ser_out, exp_ser); end
      n_cmp++; if (res_valid !== exp_valid || {res_id, res_odd} !== {exp_id, exp_odd}) begin n_bad++;
        $display("FAIL mid_result c=%0d got=%b %0d/%b exp=%b %0d/%b", now_c, res_valid, res_id, res_odd, exp_valid, exp_id, exp_odd); end
      if (exp_grant[3]) req_nx[3] = 1'b0;
    end
  endtask

  task automatic test_det_ignore();
    int d;
    req_nx = '0;
    force_det = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (res_valid !== exp_valid || busy !== exp_busy) begin n_bad++;
        $display("FAIL ign_idle c=%0d got=%b%b exp=%b%b", now_c, res_valid, busy, exp_valid, exp_busy); end
    end
    req_nx[0] = 1'b1; data_nx[2:0] = 3'b110;
    for (int i = 0; i < 14; i++) begin
      d = cyc - last_g;
      force_det = !(d >= 4 && d <= 6);
      tick();
      n_cmp++; if (ser_out !== exp_ser) begin n_bad++; $display("FAIL ign_ser c=%0d got=%b exp=%b", now_c, ser_out, exp_ser); end
      n_cmp++; if (res_valid !== exp_valid || {res_id, res_odd} !== {exp_id, exp_odd}) begin n_bad++;
        $display("FAIL ign_result c=%0d got=%b %0d/%b exp=%b %0d/%b", now_c, res_valid, res_id, res_odd, exp_valid, exp_id, exp_odd); end
      if (exp_grant[0]) req_nx[0] = 1'b0;
    end
    force_det = 1'b0;
    n_cmp++; if ({res_id, res_odd} !== {IDW'(0), 1'b0}) begin n_bad++; $display("FAIL ign_verdict got=%0d/%b exp=0/0", res_id, res_odd); end
  endtask

  task automatic test_random();
    logic [N-1:0] prev_g;
    int d;
    prev_g = '0;
    for (int t = 0; t < 470; t++) begin
      if (t < 450) begin
        for (int k = 0; k < N; k++) begin
          if (!prev_g[k[KW-1:0]]) begin
            if (req_nx[k[KW-1:0]]) begin
              if ($urandom_range(0, 15) == 0) req_nx[k[KW-1:0]] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
              req_nx[k[KW-1:0]] = 1'b1;
              data_nx[3*k +: 3] = 3'($urandom_range(0, 7));
            end
          end
        end
        d = cyc - last_g;
        force_det = !(d >= 4 && d <= 6) && ($urandom_range(0, 3) == 0);
      end else begin
        req_nx = '0;
        force_det = 1'b0;
      end
      tick();
      n_cmp++; if (grant !== exp_grant) begin n_bad++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", now_c, grant, exp_grant); end
      n_cmp++; if (ser_out !== exp_ser) begin n_bad++; $display("FAIL rnd_ser c=%0d got=%b exp=%b", now_c, ser_out, exp_ser); end
      n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", now_c, busy, exp_busy); end
      n_cmp++; if (res_valid !== exp_valid) begin n_bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", now_c, res_valid, exp_valid); end
      n_cmp++; if ({res_id, res_odd} !== {exp_id, exp_odd}) begin n_bad++;
        $display("FAIL rnd_result c=%0d got=%0d/%b exp=%0d/%b", now_c, res_id, res_odd, exp_id, exp_odd); end
      for (int k = 0; k < N; k++)
        if (exp_grant[k[KW-1:0]]) req_nx[k[KW-1:0]] = ($urandom_range(0, 3) == 0);
      prev_g = exp_grant;
    end
  endtask

  initial begin
    test_reset();
    test_single(2, 3'b101);
    test_single(1, 3'b110);
    test_back_to_back();
    test_reset_mid();
    test_det_ignore();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
